// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared raster timing helpers, pattern enum and colour constants
//   Contents: 800x600@60 default timing, h_total/v_total helpers,
//             pattern_mode_t, 24-bit {R,G,B} colour constants, bar_colour lookup.
package video_pkg;

  // 800x600@60 default timing
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    CHECKER = 2'd1,
    WHITE   = 2'd2,
    BLACK   = 2'd3
  } pattern_mode_t;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Left-to-right colour bar order
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vtg_pattern.sv
// rtl/vtg_pattern.sv - combinational test-pattern mapper for the raster generator
//   Ports: hcount/vcount (position being presented next), de (active-video flag
//          for that position), mode (latched pattern), rgb (24-bit {R,G,B}).
//   Output is 0 whenever de is low.
module vtg_pattern
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic [HW-1:0] hcount,
  input  logic [VW-1:0] vcount,
  input  logic          de,
  input  pattern_mode_t mode,
  output logic [23:0]   rgb
);

  localparam int BW = H_ACTIVE / 8;

  // Widened copies so bit 3 exists even for tiny rasters
  logic [31:0] hx;
  logic [31:0] vx;
  logic [31:0] bar;
  logic        chk;

  always_comb begin
    hx  = 32'(hcount);
    vx  = 32'(vcount);
    bar = hx / BW;
    // Remainder pixels when H_ACTIVE is not a multiple of 8 stay in the last bar
    if (bar > 32'd7) bar = 32'd7;
    chk = ((hx ^ vx) & 32'd8) != 32'd0;
    rgb = RGB_BLACK;
    if (de) begin
      case (mode)
        BARS:    rgb = bar_colour(bar[2:0]);
        CHECKER: rgb = chk ? RGB_WHITE : RGB_BLACK;
        WHITE:   rgb = RGB_WHITE;
        default: rgb = RGB_BLACK;
      endcase
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster timing and test-pattern source
//   Optional feature macro: VTG_PATTERN_EN (pattern generator and mode latch).
//   Ports: pixclk (only clock), reset_n (async active-low), enable (advance raster),
//          pattern_mode (0 bars, 1 checker, 2 white, 3 black), hcount/vcount (position),
//          de, hsync, vsync, sof (pulse at 0,0), eol (pulse at last pixel),
//          frame_cnt (completed frames), rgb ({R,G,B}, 0 when macro undefined).
//   All outputs are registered and describe the position shown in the same cycle.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int FRAME_W  = 16,
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic               pixclk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [1:0]         pattern_mode,
  output logic [HW-1:0]      hcount,
  output logic [VW-1:0]      vcount,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic [23:0]        rgb
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          line_wrap;
  logic          frame_wrap;
  logic          de_nxt;
  logic          hs_act;
  logic          vs_act;

  // Outputs are decoded from the next position so they land in the same
  // cycle as the counters they describe.
  always_comb begin
    line_wrap  = (hcount == H_LAST);
    frame_wrap = line_wrap && (vcount == V_LAST);
    h_nxt      = line_wrap ? '0 : hcount + HW'(1);
    v_nxt      = vcount;
    if (line_wrap) v_nxt = (vcount == V_LAST) ? '0 : vcount + VW'(1);
    de_nxt     = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    hs_act     = (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
    vs_act     = (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
  end

  always_ff @(posedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      // Parked at the last position so the first enabled edge lands on (0,0)
      hcount    <= H_LAST;
      vcount    <= V_LAST;
      de        <= 1'b0;
      hsync     <= ~HS_POL;
      vsync     <= ~VS_POL;
      sof       <= 1'b0;
      eol       <= 1'b0;
      frame_cnt <= '0;
    end else if (enable) begin
      hcount    <= h_nxt;
      vcount    <= v_nxt;
      de        <= de_nxt;
      hsync     <= hs_act ? HS_POL : ~HS_POL;
      vsync     <= vs_act ? VS_POL : ~VS_POL;
      sof       <= frame_wrap;
      eol       <= (h_nxt == H_LAST);
      if (frame_wrap) frame_cnt <= frame_cnt + FRAME_W'(1);
    end else begin
      // Stalled: hold position, but never repeat a strobe
      sof <= 1'b0;
      eol <= 1'b0;
    end
  end

`ifdef VTG_PATTERN_EN
  pattern_mode_t mode_q;
  pattern_mode_t mode_nxt;
  logic [23:0]   rgb_nxt;

  // The new mode already applies to the (0,0) pixel produced by the wrap edge
  assign mode_nxt = frame_wrap ? pattern_mode_t'(pattern_mode) : mode_q;

  vtg_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .HW       (HW),
    .VW       (VW)
  ) u_pattern (
    .hcount (h_nxt),
    .vcount (v_nxt),
    .de     (de_nxt),
    .mode   (mode_nxt),
    .rgb    (rgb_nxt)
  );

  always_ff @(posedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= BARS;
      rgb    <= '0;
    end else if (enable) begin
      mode_q <= mode_nxt;
      rgb    <= rgb_nxt;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^pattern_mode;
  assign rgb         = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen (three raster sizes)
`timescale 1ns/1ps
module tb_video_timing_gen;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        de;
    logic        hs;
    logic        vs;
    logic        sof;
    logic        eol;
    logic [15:0] fc;
    logic [23:0] rgb;
  } vis_t;

  typedef struct packed {
    vis_t       vis;
    logic [1:0] mode;
  } st_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hpol, vpol;
    int fw;
  } cfg_t;

`ifdef VTG_PATTERN_EN
  localparam logic [23:0] X_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] X_MAGENTA = 24'hFF00FF;
`else
  localparam logic [23:0] X_WHITE   = 24'h000000;
  localparam logic [23:0] X_MAGENTA = 24'h000000;
`endif

  localparam int HW_A = 11, VW_A = 10;
  localparam int HW_B = 5,  VW_B = 4;
  localparam int HW_C = 4,  VW_C = 3;

  cfg_t cfg_a = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 16};
  cfg_t cfg_b = '{16, 2, 3, 2, 6, 1, 2, 1, 1'b0, 1'b0, 4};
  cfg_t cfg_c = '{8, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1, 2};

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a; logic [1:0] pm_a;
  logic [HW_A-1:0] h_a; logic [VW_A-1:0] v_a;
  logic de_a, hs_a, vs_a, sof_a, eol_a; logic [15:0] fc_a; logic [23:0] rgb_a;

  logic rst_b, en_b; logic [1:0] pm_b;
  logic [HW_B-1:0] h_b; logic [VW_B-1:0] v_b;
  logic de_b, hs_b, vs_b, sof_b, eol_b; logic [3:0] fc_b; logic [23:0] rgb_b;

  logic rst_c, en_c; logic [1:0] pm_c;
  logic [HW_C-1:0] h_c; logic [VW_C-1:0] v_c;
  logic de_c, hs_c, vs_c, sof_c, eol_c; logic [1:0] fc_c; logic [23:0] rgb_c;

  video_timing_gen dut_a (
    .pixclk(clk), .reset_n(rst_a), .enable(en_a), .pattern_mode(pm_a),
    .hcount(h_a), .vcount(v_a), .de(de_a), .hsync(hs_a), .vsync(vs_a),
    .sof(sof_a), .eol(eol_a), .frame_cnt(fc_a), .rgb(rgb_a)
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FRAME_W(4)
  ) dut_b (
    .pixclk(clk), .reset_n(rst_b), .enable(en_b), .pattern_mode(pm_b),
    .hcount(h_b), .vcount(v_b), .de(de_b), .hsync(hs_b), .vsync(vs_b),
    .sof(sof_b), .eol(eol_b), .frame_cnt(fc_b), .rgb(rgb_b)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .FRAME_W(2)
  ) dut_c (
    .pixclk(clk), .reset_n(rst_c), .enable(en_c), .pattern_mode(pm_c),
    .hcount(h_c), .vcount(v_c), .de(de_c), .hsync(hs_c), .vsync(vs_c),
    .sof(sof_c), .eol(eol_c), .frame_cnt(fc_c), .rgb(rgb_c)
  );

  int n_checks;
  int n_fail;

  st_t  q_a[$], q_b[$], q_c[$];
  st_t  cur_a, cur_b, cur_c;
  st_t  exp_a, exp_b, exp_c;
  vis_t obs_a, obs_b, obs_c;

  function automatic st_t reset_state(cfg_t c);
    st_t s;
    s = '0;
    s.vis.h  = 16'(c.ha + c.hf + c.hs + c.hb - 1);
    s.vis.v  = 16'(c.va + c.vf + c.vs + c.vb - 1);
    s.vis.hs = ~c.hpol;
    s.vis.vs = ~c.vpol;
    return s;
  endfunction

  function automatic st_t model_step(cfg_t c, st_t s, logic rst, logic en, logic [1:0] pm);
    st_t n;
    int ht, vt, h, v, idx;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    if (!rst) return reset_state(c);
    n = s;
    n.vis.sof = 1'b0;
    n.vis.eol = 1'b0;
    if (!en) return n;
    h = int'(s.vis.h);
    v = int'(s.vis.v);
    if (h == ht - 1) begin
      h = 0;
      if (v == vt - 1) begin
        v = 0;
        n.vis.sof = 1'b1;
        n.vis.fc  = 16'((int'(s.vis.fc) + 1) % (1 << c.fw));
        n.mode    = pm;
      end else begin
        v = v + 1;
      end
    end else begin
      h = h + 1;
    end
    n.vis.h   = 16'(h);
    n.vis.v   = 16'(v);
    n.vis.eol = (h == ht - 1);
    n.vis.de  = (h < c.ha) && (v < c.va);
    n.vis.hs  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hpol : ~c.hpol;
    n.vis.vs  = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vpol : ~c.vpol;
    n.vis.rgb = 24'h0;
`ifdef VTG_PATTERN_EN
    if (n.vis.de) begin
      case (n.mode)
        2'd0: begin
          idx = h / (c.ha / 8);
          if (idx > 7) idx = 7;
          n.vis.rgb = bars[idx];
        end
        2'd1: n.vis.rgb = ((((h >> 3) ^ (v >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
        2'd2: n.vis.rgb = 24'hFFFFFF;
        default: n.vis.rgb = 24'h0;
      endcase
    end
`else
    idx = 0;
`endif
    return n;
  endfunction

  function automatic vis_t cap_a();
    vis_t o;
    o.h = 16'(h_a); o.v = 16'(v_a); o.de = de_a; o.hs = hs_a; o.vs = vs_a;
    o.sof = sof_a; o.eol = eol_a; o.fc = fc_a; o.rgb = rgb_a;
    return o;
  endfunction

  function automatic vis_t cap_b();
    vis_t o;
    o.h = 16'(h_b); o.v = 16'(v_b); o.de = de_b; o.hs = hs_b; o.vs = vs_b;
    o.sof = sof_b; o.eol = eol_b; o.fc = 16'(fc_b); o.rgb = rgb_b;
    return o;
  endfunction

  function automatic vis_t cap_c();
    vis_t o;
    o.h = 16'(h_c); o.v = 16'(v_c); o.de = de_c; o.hs = hs_c; o.vs = vs_c;
    o.sof = sof_c; o.eol = eol_c; o.fc = 16'(fc_c); o.rgb = rgb_c;
    return o;
  endfunction

  // Push the expected outcome of the coming edge, then pop it once the DUT has produced it
  task automatic tick();
    cur_a = model_step(cfg_a, cur_a, rst_a, en_a, pm_a); q_a.push_back(cur_a);
    cur_b = model_step(cfg_b, cur_b, rst_b, en_b, pm_b); q_b.push_back(cur_b);
    cur_c = model_step(cfg_c, cur_c, rst_c, en_c, pm_c); q_c.push_back(cur_c);
    @(posedge clk);
    #1;
    exp_a = q_a.pop_front(); obs_a = cap_a();
    exp_b = q_b.pop_front(); obs_b = cap_b();
    exp_c = q_c.pop_front(); obs_c = cap_c();
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    pm_a = 2'd0; pm_b = 2'd0; pm_c = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    cur_a = reset_state(cfg_a); cur_b = reset_state(cfg_b); cur_c = reset_state(cfg_c);
    obs_a = cap_a(); obs_b = cap_b(); obs_c = cap_c();
    n_checks++;
    if (obs_a !== cur_a.vis) begin n_fail++; $display("FAIL reset_a got=%h exp=%h", obs_a, cur_a.vis); end
    n_checks++;
    if (obs_b !== cur_b.vis) begin n_fail++; $display("FAIL reset_b got=%h exp=%h", obs_b, cur_b.vis); end
    n_checks++;
    if (obs_c !== cur_c.vis) begin n_fail++; $display("FAIL reset_c got=%h exp=%h", obs_c, cur_c.vis); end
    n_checks++;
    if (h_a !== 11'd1055 || v_a !== 10'd627 || hs_a !== 1'b0 || hs_b !== 1'b1)
      begin n_fail++; $display("FAIL reset_pos got h=%0d v=%0d hs_a=%b hs_b=%b exp h=1055 v=627 hs_a=0 hs_b=1", h_a, v_a, hs_a, hs_b); end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
  endtask

  task automatic test_first_edge();
    en_a = 1'b1;
    tick();
    n_checks++;
    if (obs_a !== exp_a.vis) begin n_fail++; $display("FAIL first_model got=%h exp=%h", obs_a, exp_a.vis); end
    n_checks++;
    if (obs_a.h !== 16'd0 || obs_a.v !== 16'd0 || obs_a.de !== 1'b1 || obs_a.sof !== 1'b1 ||
        obs_a.fc !== 16'd1 || obs_a.rgb !== X_WHITE)
      begin n_fail++; $display("FAIL first_edge got h=%0d v=%0d de=%b sof=%b fc=%0d rgb=%h exp 0 0 1 1 1 %h",
        obs_a.h, obs_a.v, obs_a.de, obs_a.sof, obs_a.fc, obs_a.rgb, X_WHITE); end
  endtask

  task automatic test_line();
    int de_cnt, hs_cnt, hs_first, hs_last, eol_cnt, eol_h;
    de_cnt = int'(obs_a.de); hs_cnt = int'(obs_a.hs);
    hs_first = -1; hs_last = -1; eol_cnt = 0; eol_h = -1;
    for (int i = 0; i < 1055; i++) begin
      tick();
      n_checks++;
      if (obs_a !== exp_a.vis) begin n_fail++; $display("FAIL line_model h=%0d got=%h exp=%h", exp_a.vis.h, obs_a, exp_a.vis); end
      if (obs_a.v == 16'd0) begin
        if (obs_a.de) de_cnt++;
        if (obs_a.hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(obs_a.h);
          hs_last = int'(obs_a.h);
        end
        if (obs_a.eol) begin eol_cnt++; eol_h = int'(obs_a.h); end
      end
    end
    n_checks++;
    if (de_cnt != 800) begin n_fail++; $display("FAIL line_de_count got=%0d exp=800", de_cnt); end
    n_checks++;
    if (hs_cnt != 128 || hs_first != 840 || hs_last != 967)
      begin n_fail++; $display("FAIL line_hsync got cnt=%0d first=%0d last=%0d exp 128 840 967", hs_cnt, hs_first, hs_last); end
    n_checks++;
    if (eol_cnt != 1 || eol_h != 1055) begin n_fail++; $display("FAIL line_eol got cnt=%0d h=%0d exp 1 1055", eol_cnt, eol_h); end
  endtask

  task automatic test_enable_gap();
    int en_cycles;
    bit gap_done, got_eol;
    vis_t snap;
    en_cycles = 0; gap_done = 0; got_eol = 0;
    for (int i = 0; i < 3000 && !got_eol; i++) begin
      if (!gap_done && obs_a.h == 16'd300) begin
        snap = obs_a;
        en_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
          tick();
          n_checks++;
          if (obs_a !== snap || obs_a !== exp_a.vis)
            begin n_fail++; $display("FAIL gap_hold k=%0d got=%h exp=%h", k, obs_a, snap); end
        end
        en_a = 1'b1;
        gap_done = 1;
      end
      tick();
      en_cycles++;
      n_checks++;
      if (obs_a !== exp_a.vis) begin n_fail++; $display("FAIL gap_model got=%h exp=%h", obs_a, exp_a.vis); end
      if (obs_a.eol) got_eol = 1;
    end
    n_checks++;
    if (!gap_done || !got_eol || en_cycles != 1056 || obs_a.v !== 16'd1)
      begin n_fail++; $display("FAIL gap_line_len got cycles=%0d gap=%0d eol=%0d v=%0d exp 1056 1 1 1",
        en_cycles, gap_done, got_eol, obs_a.v); end
  endtask

  task automatic test_frame();
    int t, sof_n;
    int sof_t [3];
    logic [9:0] vs_mask;
    logic [23:0] rgb_bar, rgb_chk;
    t = 0; sof_n = 0; vs_mask = '0; rgb_bar = 24'hx; rgb_chk = 24'hx;
    en_b = 1'b1; pm_b = 2'd0;
    for (int i = 0; i < 461; i++) begin
      tick();
      t++;
      n_checks++;
      if (obs_b !== exp_b.vis) begin n_fail++; $display("FAIL frame_model t=%0d got=%h exp=%h", t, obs_b, exp_b.vis); end
      if (obs_b.sof) begin
        if (sof_n < 3) sof_t[sof_n] = t;
        sof_n++;
      end
      if (sof_n == 1 && obs_b.h == 16'd0 && obs_b.vs == 1'b0) vs_mask[obs_b.v[3:0]] = 1'b1;
      if (sof_n == 1 && obs_b.h == 16'd0 && obs_b.v == 16'd3) pm_b = 2'd1;
      if (sof_n == 1 && obs_b.h == 16'd8 && obs_b.v == 16'd4) rgb_bar = obs_b.rgb;
      if (sof_n == 2 && obs_b.h == 16'd8 && obs_b.v == 16'd0) rgb_chk = obs_b.rgb;
    end
    en_b = 1'b0;
    n_checks++;
    if (sof_n != 3 || sof_t[0] != 1 || sof_t[1] - sof_t[0] != 230 || sof_t[2] - sof_t[1] != 230)
      begin n_fail++; $display("FAIL frame_sof got n=%0d t0=%0d t1=%0d t2=%0d exp 3 1 231 461", sof_n, sof_t[0], sof_t[1], sof_t[2]); end
    n_checks++;
    if (vs_mask !== 10'b01_1000_0000) begin n_fail++; $display("FAIL frame_vsync_lines got=%b exp=0110000000", vs_mask); end
    n_checks++;
    if (rgb_bar !== X_MAGENTA) begin n_fail++; $display("FAIL frame_bars_persist got=%h exp=%h", rgb_bar, X_MAGENTA); end
    n_checks++;
    if (rgb_chk !== X_WHITE) begin n_fail++; $display("FAIL frame_checker_start got=%h exp=%h", rgb_chk, X_WHITE); end
  endtask

  task automatic test_small_wrap();
    int fcs[$];
    en_c = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if (obs_c !== exp_c.vis) begin n_fail++; $display("FAIL small_model got=%h exp=%h", obs_c, exp_c.vis); end
    end
    rst_c = 1'b0;
    #1;
    cur_c = reset_state(cfg_c);
    q_c.delete();
    obs_c = cap_c();
    n_checks++;
    if (obs_c !== cur_c.vis || h_c !== 4'd10 || v_c !== 3'd4 || fc_c !== 2'd0)
      begin n_fail++; $display("FAIL small_reset got=%h exp=%h", obs_c, cur_c.vis); end
    rst_c = 1'b1;
    tick();
    n_checks++;
    if (obs_c.sof !== 1'b1 || obs_c.h !== 16'd0 || obs_c.v !== 16'd0 || obs_c.fc !== 16'd1)
      begin n_fail++; $display("FAIL small_restart got sof=%b h=%0d v=%0d fc=%0d exp 1 0 0 1", obs_c.sof, obs_c.h, obs_c.v, obs_c.fc); end
    for (int i = 0; i < 200; i++) begin
      tick();
      n_checks++;
      if (obs_c !== exp_c.vis) begin n_fail++; $display("FAIL small_model got=%h exp=%h", obs_c, exp_c.vis); end
      if (obs_c.sof) fcs.push_back(int'(obs_c.fc));
    end
    n_checks++;
    if (fcs.size() != 3 || fcs[0] != 2 || fcs[1] != 3 || fcs[2] != 0)
      begin n_fail++; $display("FAIL small_fc_wrap got n=%0d seq=%p exp 2,3,0", fcs.size(), fcs); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_first_edge();
    test_line();
    test_enable_gap();
    test_frame();
    test_small_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing and test-pattern source for the HDMI path. It generates pixel/line counters, data-enable and sync strobes, and frame markers for any CEA/VESA-style mode, and can optionally produce RGB test patterns. It sits in `hdmi_top` ahead of the TMDS encoders and replaces the fixed 800x600 counter logic, so the TMDS path can be reused across resolutions.

## Interface
- `H_ACTIVE`, 800, visible pixels per line (≥ 8)
- `H_FP`, 40 / `H_SYNC`, 128 / `H_BP`, 88: horizontal porch and sync widths, in pixels (each ≥ 1)
- `V_ACTIVE`, 600 / `V_FP`, 1 / `V_SYNC`, 4 / `V_BP`, 23: vertical widths, in lines (each ≥ 1)
- `HS_POL`, 1 / `VS_POL`, 1: active level of each sync
- `FRAME_W`, 16: width of the frame counter
- `pixclk`  in  1  pixel clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  advance the raster; when low, all state holds
- `pattern_mode`  in  2  0 = colour bars, 1 = checkerboard, 2 = white, 3 = black
- `hcount`  out  clog2(H_TOTAL)  current pixel index
- `vcount`  out  clog2(V_TOTAL)  current line index
- `de`  out  1  active-video flag
- `hsync`, `vsync`  out  1 each  sync strobes, driven at the configured polarity
- `sof`  out  1  start-of-frame: one-cycle pulse at (0,0)
- `eol`  out  1  end-of-line: one-cycle pulse at `hcount` = H_TOTAL-1
- `frame_cnt`  out  FRAME_W  completed-frame count
- `rgb`  out  24  pixel data {R,G,B}, 8 bits per channel

## Operation
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP. V_TOTAL is formed the same way from the vertical parameters.
- All outputs are registered. Each output describes the position (`hcount`, `vcount`) presented in the same cycle. The implementation computes outputs from the next-state counter values.
- Reset state: `hcount` = H_TOTAL-1, `vcount` = V_TOTAL-1, `de` = 0, `hsync` = ~HS_POL, `vsync` = ~VS_POL, `sof` = 0, `eol` = 0, `frame_cnt` = 0, `rgb` = 0, latched mode = 0.
- Advance rule, applied on each edge with `enable` = 1:
  - `hcount` increments.
  - At H_TOTAL-1, `hcount` wraps to 0 and `vcount` increments.
  - At (H_TOTAL-1, V_TOTAL-1), the position wraps to (0,0); `sof` = 1 and `frame_cnt` increments, wrapping modulo 2^FRAME_W.
- `de` = 1 exactly when `hcount` < H_ACTIVE and `vcount` < V_ACTIVE.
- `hsync` is active for `hcount` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- `vsync` is active for `vcount` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. It changes together with the line wrap at `hcount` = 0.
- `enable` = 0: counters, syncs, `de`, `rgb` and `frame_cnt` all hold. `sof` and `eol` are forced to 0, so a pulse is never repeated.
- `pattern_mode` is sampled only on the edge that produces `sof`. A mid-frame change takes effect at the next frame.
- Reset asserted mid-frame: all outputs take their reset state immediately. After release, the first enabled edge produces (0,0) with `sof` = 1.

## Timing
- Latency from counter position to `de`, syncs and `rgb`: zero. These outputs are cycle-aligned with `hcount` and `vcount`.
- First active pixel appears on the first enabled edge after `reset_n` rises.
- Steady state: one pixel per enabled `pixclk` cycle. A frame is H_TOTAL × V_TOTAL enabled cycles (663 168 at the defaults).

## Configuration
- `VTG_PATTERN_EN` defined:
  - `rgb` carries the pattern selected by the latched mode, and is 0 whenever `de` = 0.
  - Colour bars: BW = H_ACTIVE/8 (integer division), bar index = min(`hcount`/BW, 7).
  - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Checkerboard: FFFFFF when `hcount`[3] ^ `vcount`[3] = 1, else 000000.
- `VTG_PATTERN_EN` undefined:
  - The `rgb` port remains, tied to 0.
  - `pattern_mode` is ignored; the pattern logic and mode latch are not built.

## Structure
- Shared package `video_pkg` holds:
  - the H_TOTAL/V_TOTAL helper functions;
  - `pattern_mode_t` enum (BARS, CHECKER, WHITE, BLACK);
  - the 24-bit colour constants;
  - the 800x600@60 default timing constants.
- One sub-module, `vtg_pattern`, maps (next `hcount`, next `vcount`, next `de`, mode) to `rgb`. It is instantiated only under `VTG_PATTERN_EN`.

## Test plan
- Reset then release at defaults, `enable` = 1 → first edge gives (0,0), `de` = 1, `sof` = 1, `rgb` = FFFFFF, `frame_cnt` = 1.
- Observe one line → `de` high for 800 cycles; `hsync` = 1 for `hcount` 840..967 (128 cycles); `eol` at `hcount` 1055.
- Run one full frame → `vsync` high for lines 601..604; next `sof` exactly 663 168 cycles after the first.
- Toggle `enable` low for 10 cycles mid-line → all outputs frozen; no extra `sof`/`eol`; line length counted in enabled cycles stays 1056.
- `pattern_mode` 0→1 at line 300 → bars persist to end of frame; checkerboard starts at next `sof`. With the macro undefined, `rgb` = 0 throughout.
- Small mode (H = 8,1,1,1; V = 2,1,1,1) with `FRAME_W` = 2, `reset_n` pulsed mid-frame → reset values reached immediately; `frame_cnt` wraps 3→0 on the 4th frame.
